register_file: RTL and testbench

- Architectural register file for the single-cycle MIPS core. Sits directly downstream of instruction memory: the rs/rt fields of the fetched instruction drive the read ports, and the writeback path drives the write port.
- Provides 32 general-purpose registers with two asynchronous read ports and one synchronous write port. $0 is hardwired to zero.
- Optional same-cycle write-to-read bypass.

---
 rtl/register_file.sv | 97 +++++++++
 tb/tb_register_file.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
//   Architectural register file for the single-cycle MIPS core.
//   2**ADDR_WIDTH entries of DATA_WIDTH bits, two combinational read ports,
//   one synchronous write port. Entry 0 is hardwired to zero.
//
// Parameters
//   DATA_WIDTH : register width in bits
//   ADDR_WIDTH : register index width (depth = 2**ADDR_WIDTH)
//   BYPASS     : 1 = a read of the register being written this cycle returns
//                write_data; 0 = returns the stored (old) value
//
// Ports
//   clk        : rising-edge clock
//   reset      : synchronous, active-high; clears every entry
//   read_reg1  : read port 1 index (rs)
//   read_reg2  : read port 2 index (rt)
//   write_reg  : write index (rt or rd, selected upstream)
//   write_data : writeback value
//   reg_write  : write enable
//   read_data1 : contents of read_reg1 (combinational)
//   read_data2 : contents of read_reg2 (combinational)
// ---------------------------------------------------------------------------
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  reg_write,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_r [0:DEPTH-1];

  // A write that actually lands at the next edge; only such a write may be
  // forwarded, so reset and writes to $0 never bypass.
  logic write_en_s;
  logic bypass_en_s;

  // Qualify the write enable and the bypass enable.
  always_comb begin
    write_en_s  = 1'b0;
    bypass_en_s = 1'b0;
    if (reg_write && !reset && (write_reg != '0)) begin
      write_en_s  = 1'b1;
      bypass_en_s = (BYPASS != 32'sd0);
    end else begin
      write_en_s  = 1'b0;
      bypass_en_s = 1'b0;
    end
  end

  // Storage update: reset clears everything and wins over a concurrent write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= '0;
      end
    end else if (write_en_s) begin
      regs_r[write_reg] <= write_data;
    end
  end

  // Read port 1: $0 forced to zero, then same-cycle forwarding, then storage.
  always_comb begin
    read_data1 = '0;
    if (read_reg1 == '0) begin
      read_data1 = '0;
    end else if (bypass_en_s && (read_reg1 == write_reg)) begin
      read_data1 = write_data;
    end else begin
      read_data1 = regs_r[read_reg1];
    end
  end

  // Read port 2: same selection order as port 1.
  always_comb begin
    read_data2 = '0;
    if (read_reg2 == '0) begin
      read_data2 = '0;
    end else if (bypass_en_s && (read_reg2 == write_reg)) begin
      read_data2 = write_data;
    end else begin
      read_data2 = regs_r[read_reg2];
    end
  end

endmodule

// File: tb/tb_register_file.sv
// ---------------------------------------------------------------------------
// tb_register_file
//   Directed bench for register_file. Two instances share every input: one
//   built with BYPASS=1, one with BYPASS=0, so each read observation checks
//   both flavours at once. Inputs change on the falling edge; outputs are
//   sampled either mid-low-phase (before the next rising edge) or #1 after
//   the rising edge.
// ---------------------------------------------------------------------------
module tb_register_file;

  logic        clk;
  logic        reset;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        reg_write;
  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;

  int tests;
  int fails;

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1)) dut_b (
    .clk(clk), .reset(reset), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
    .read_data1(rd1_b), .read_data2(rd2_b)
  );

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0)) dut_n (
    .clk(clk), .reset(reset), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
    .read_data1(rd1_n), .read_data2(rd2_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single write through one rising edge; leaves reg_write low afterwards.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    reg_write  = 1'b1;
    write_reg  = a;
    write_data = d;
    @(posedge clk);
    #1;
    reg_write = 1'b0;
  endtask

  // Observed value layout for every comparison: {rd1_b, rd2_b, rd1_n, rd2_n}.
  task automatic test_reset();
    logic [127:0] exp;
    do_write(5'd3, 32'h1111_2222);
    do_write(5'd20, 32'h3333_4444);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i);
      read_reg2 = 5'(31 - i);
      #1;
      exp = 128'h0;
      tests++;
      if ({rd1_b, rd2_b, rd1_n, rd2_n} !== exp) begin
        fails++;
        $display("FAIL reset_sweep idx=%0d got %h expected %h", i,
                 {rd1_b, rd2_b, rd1_n, rd2_n}, exp);
      end
    end
  endtask

  task automatic test_write_readback();
    logic [127:0] exp;
    do_write(5'd8, 32'hDEAD_BEEF);
    do_write(5'd31, 32'h1234_5678);
    read_reg1 = 5'd8;
    read_reg2 = 5'd31;
    #1;
    exp = {32'hDEAD_BEEF, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678};
    tests++;
    if ({rd1_b, rd2_b, rd1_n, rd2_n} !== exp) begin
      fails++;
      $display("FAIL write_readback got %h expected %h", {rd1_b, rd2_b, rd1_n, rd2_n}, exp);
    end
    // Same index on both ports returns identical data.
    read_reg2 = 5'd8;
    #1;
    exp = {32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    tests++;
    if ({rd1_b, rd2_b, rd1_n, rd2_n} !== exp) begin
      fails++;
      $display("FAIL same_index got %h expected %h", {rd1_b, rd2_b, rd1_n, rd2_n}, exp);
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    reg_write  = 1'b1;
    write_reg  = 5'd0;
    write_data = 32'hFFFF_FFFF;
    read_reg1  = 5'd0;
    read_reg2  = 5'd0;
    #1;
    tests++;
    if ({rd1_b, rd2_b, rd1_n, rd2_n} !== 128'h0) begin
      fails++;
      $display("FAIL zero_before_edge got %h expected %h", {rd1_b, rd2_b, rd1_n, rd2_n}, 128'h0);
    end
    @(posedge clk);
    #1;
    reg_write = 1'b0;
    tests++;
    if ({rd1_b, rd2_b, rd1_n, rd2_n} !== 128'h0) begin
      fails++;
      $display("FAIL zero_after_edge got %h expected %h", {rd1_b, rd2_b, rd1_n, rd2_n}, 128'h0);
    end
  endtask

  task automatic test_bypass();
    logic [127:0] exp;
    do_write(5'd5, 32'h1);
    @(negedge clk);
    reg_write  = 1'b1;
    write_reg  = 5'd5;
    write_data = 32'h2;
    read_reg1  = 5'd5;
    read_reg2  = 5'd5;
    #1;
    exp = {32'h2, 32'h2, 32'h1, 32'h1};
    tests++;
    if ({rd1_b, rd2_b, rd1_n, rd2_n} !== exp) begin
      fails++;
      $display("FAIL bypass_before_edge got %h expected %h", {rd1_b, rd2_b, rd1_n, rd2_n}, exp);
    end
    @(posedge clk);
    #1;
    reg_write = 1'b0;
    exp = {32'h2, 32'h2, 32'h2, 32'h2};
    tests++;
    if ({rd1_b, rd2_b, rd1_n, rd2_n} !== exp) begin
      fails++;
      $display("FAIL bypass_after_edge got %h expected %h", {rd1_b, rd2_b, rd1_n, rd2_n}, exp);
    end
    // Only port 1 matches the write index; port 2 must see stored $5.
    @(negedge clk);
    reg_write  = 1'b1;
    write_reg  = 5'd6;
    write_data = 32'h66;
    read_reg1  = 5'd6;
    read_reg2  = 5'd5;
    #1;
    exp = {32'h66, 32'h2, 32'h0, 32'h2};
    tests++;
    if ({rd1_b, rd2_b, rd1_n, rd2_n} !== exp) begin
      fails++;
      $display("FAIL bypass_one_port got %h expected %h", {rd1_b, rd2_b, rd1_n, rd2_n}, exp);
    end
    @(posedge clk);
    #1;
    // No forwarding while reset is high; stored value shows, then zero.
    write_reg  = 5'd5;
    write_data = 32'h3;
    reset      = 1'b1;
    read_reg1  = 5'd5;
    read_reg2  = 5'd6;
    #1;
    exp = {32'h2, 32'h66, 32'h2, 32'h66};
    tests++;
    if ({rd1_b, rd2_b, rd1_n, rd2_n} !== exp) begin
      fails++;
      $display("FAIL reset_no_bypass got %h expected %h", {rd1_b, rd2_b, rd1_n, rd2_n}, exp);
    end
    @(posedge clk);
    #1;
    reset     = 1'b0;
    reg_write = 1'b0;
    tests++;
    if ({rd1_b, rd2_b, rd1_n, rd2_n} !== 128'h0) begin
      fails++;
      $display("FAIL reset_clears_after got %h expected %h", {rd1_b, rd2_b, rd1_n, rd2_n}, 128'h0);
    end
  endtask

  task automatic test_reset_priority();
    logic [127:0] exp;
    do_write(5'd9, 32'hA5A5_A5A5);
    read_reg1 = 5'd9;
    read_reg2 = 5'd9;
    #1;
    exp = {4{32'hA5A5_A5A5}};
    tests++;
    if ({rd1_b, rd2_b, rd1_n, rd2_n} !== exp) begin
      fails++;
      $display("FAIL prio_preload got %h expected %h", {rd1_b, rd2_b, rd1_n, rd2_n}, exp);
    end
    @(negedge clk);
    reset      = 1'b1;
    reg_write  = 1'b1;
    write_reg  = 5'd9;
    write_data = 32'h5A5A_5A5A;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    reg_write = 1'b0;
    #1;
    tests++;
    if ({rd1_b, rd2_b, rd1_n, rd2_n} !== 128'h0) begin
      fails++;
      $display("FAIL reset_priority got %h expected %h", {rd1_b, rd2_b, rd1_n, rd2_n}, 128'h0);
    end
  endtask

  task automatic test_write_enable_low();
    logic [127:0] exp;
    do_write(5'd12, 32'h7);
    @(negedge clk);
    reg_write  = 1'b0;
    write_reg  = 5'd12;
    write_data = 32'hCAFE_0000;
    read_reg1  = 5'd12;
    read_reg2  = 5'd12;
    repeat (3) @(posedge clk);
    #1;
    exp = {4{32'h7}};
    tests++;
    if ({rd1_b, rd2_b, rd1_n, rd2_n} !== exp) begin
      fails++;
      $display("FAIL we_low got %h expected %h", {rd1_b, rd2_b, rd1_n, rd2_n}, exp);
    end
  endtask

  // Writes on consecutive edges; each value is readable right after its edge.
  task automatic test_back_to_back();
    logic [127:0] exp;
    logic [31:0]  vals [4];
    vals[0] = 32'h0000_0011;
    vals[1] = 32'h0000_2200;
    vals[2] = 32'h0033_0000;
    vals[3] = 32'h4400_0000;
    @(negedge clk);
    reg_write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      write_reg  = 5'(i + 1);
      write_data = vals[i];
      read_reg1  = 5'(i + 1);
      read_reg2  = 5'(i + 1);
      @(posedge clk);
      #1;
      reg_write = 1'b0;
      #1;
      exp = {4{vals[i]}};
      tests++;
      if ({rd1_b, rd2_b, rd1_n, rd2_n} !== exp) begin
        fails++;
        $display("FAIL back_to_back reg=%0d got %h expected %h", i + 1,
                 {rd1_b, rd2_b, rd1_n, rd2_n}, exp);
      end
      @(negedge clk);
      reg_write = 1'b1;
    end
    reg_write = 1'b0;
    read_reg1 = 5'd1;
    read_reg2 = 5'd4;
    #1;
    exp = {vals[0], vals[3], vals[0], vals[3]};
    tests++;
    if ({rd1_b, rd2_b, rd1_n, rd2_n} !== exp) begin
      fails++;
      $display("FAIL back_to_back_final got %h expected %h", {rd1_b, rd2_b, rd1_n, rd2_n}, exp);
    end
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    reset      = 1'b1;
    reg_write  = 1'b0;
    write_reg  = 5'd0;
    write_data = 32'h0;
    read_reg1  = 5'd0;
    read_reg2  = 5'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    test_reset();
    test_write_readback();
    test_zero_reg();
    test_bypass();
    test_reset_priority();
    test_write_enable_low();
    test_back_to_back();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
